// File: rtl/lcd_responder_if.sv
//==============================================================================
// Module      : lcd_responder_if
// Description : HD44780-style parallel bus between an LCD writer and responder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface lcd_responder_if;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic [7:0] lcd_dout;
    logic       lcd_dout_en;

    modport master (
        output lcd_rs, lcd_rw, lcd_e, lcd_data,
        input  lcd_dout, lcd_dout_en
    );

    modport slave (
        input  lcd_rs, lcd_rw, lcd_e, lcd_data,
        output lcd_dout, lcd_dout_en
    );
endinterface

`default_nettype wire

// File: rtl/lcd_responder.sv
//==============================================================================
// Module      : lcd_responder
// Description : Behavioural HD44780 character-LCD responder (2x16 visible).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lcd_responder #(
    parameter int BUSY_CYCLES    = 4000,
    parameter int CLEAR_CYCLES   = 152000,
    parameter int POWERUP_CYCLES = 1000000
) (
    input  logic           clk,
    input  logic           reset,
    lcd_responder_if.slave bus,
    output logic [127:0]   line1,
    output logic [127:0]   line2,
    output logic [6:0]     addr_counter,
    output logic           busy,
    output logic           display_on,
    output logic           cursor_on,
    output logic           blink_on,
    output logic           inc_mode,
    output logic           func_8bit,
    output logic           func_2line,
    output logic           cmd_strobe,
    output logic           data_strobe,
    output logic           protocol_error
);

    localparam logic [7:0]   c_SPACE      = 8'h20;
    localparam logic [127:0] c_BLANK_LINE = {16{c_SPACE}};

    typedef enum logic [2:0] {
        S_POWERUP = 3'd0,
        S_IDLE    = 3'd1,
        S_EXEC    = 3'd2,
        S_CLEAR   = 3'd3,
        S_BUSY    = 3'd4
    } state_t;

    state_t       r_state;
    logic [31:0]  r_cnt;
    logic [4:0]   r_fill;
    logic         r_e_q;
    logic         r_rs_q;
    logic         r_rw_q;
    logic [7:0]   r_data_q;
    logic         r_op_rs;
    logic [7:0]   r_op_data;
    logic [127:0] r_line1;
    logic [127:0] r_line2;
    logic [6:0]   r_ac;
    logic         r_busy;
    logic         r_disp;
    logic         r_cursor;
    logic         r_blink;
    logic         r_inc;
    logic         r_f8;
    logic         r_f2;
    logic         r_cgram;
    logic         r_cmd_stb;
    logic         r_data_stb;
    logic         r_err;
    logic [7:0]   r_dout;
    logic         r_dout_en;

    logic         w_edge;
    logic         w_write;
    logic         w_accept;
    logic         w_reject;
    logic         w_dread;
    logic         w_long;
    logic         w_addr_ok;
    logic         w_cnt_done;
    logic [7:0]   w_cell;

    // AC walks 0x00..0x27 and 0x40..0x67, wrapping across the gaps.
    function automatic logic [6:0] f_step(input logic [6:0] ac, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (ac == 7'h27)      nxt = 7'h40;
            else if (ac == 7'h67) nxt = 7'h00;
            else                  nxt = ac + 7'd1;
        end else begin
            if (ac == 7'h00)      nxt = 7'h67;
            else if (ac == 7'h40) nxt = 7'h27;
            else                  nxt = ac - 7'd1;
        end
        return nxt;
    endfunction

    assign w_edge     = r_e_q & ~bus.lcd_e;
    assign w_write    = w_edge & ~r_rw_q;
    assign w_accept   = w_write & ~r_busy;
    assign w_reject   = w_write & r_busy;
    assign w_dread    = w_edge & r_rw_q & r_rs_q & ~r_busy;
    assign w_long     = ~r_rs_q & (r_data_q[7:2] == 6'd0) & (r_data_q[1:0] != 2'd0);
    assign w_addr_ok  = (r_op_data[6:0] <= 7'h27) ||
                        ((r_op_data[6:0] >= 7'h40) && (r_op_data[6:0] <= 7'h67));
    assign w_cnt_done = (r_cnt == 32'd0);

    // Character under the address counter; hidden DDRAM reads back as a space.
    always_comb begin
        w_cell = c_SPACE;
        if (r_ac < 7'h10)
            w_cell = r_line1[{~r_ac[3:0], 3'b000} +: 8];
        else if (r_ac[6:4] == 3'b100)
            w_cell = r_line2[{~r_ac[3:0], 3'b000} +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_POWERUP;
            r_cnt      <= 32'(POWERUP_CYCLES - 1);
            r_fill     <= 5'd0;
            r_e_q      <= 1'b0;
            r_rs_q     <= 1'b0;
            r_rw_q     <= 1'b0;
            r_data_q   <= 8'd0;
            r_op_rs    <= 1'b0;
            r_op_data  <= 8'd0;
            r_line1    <= c_BLANK_LINE;
            r_line2    <= c_BLANK_LINE;
            r_ac       <= 7'd0;
            r_busy     <= 1'b1;
            r_disp     <= 1'b0;
            r_cursor   <= 1'b0;
            r_blink    <= 1'b0;
            r_inc      <= 1'b1;
            r_f8       <= 1'b1;
            r_f2       <= 1'b0;
            r_cgram    <= 1'b0;
            r_cmd_stb  <= 1'b0;
            r_data_stb <= 1'b0;
            r_err      <= 1'b0;
            r_dout     <= 8'd0;
            r_dout_en  <= 1'b0;
        end else begin
            r_cmd_stb  <= 1'b0;
            r_data_stb <= 1'b0;
            r_err      <= w_reject;

            r_e_q <= bus.lcd_e;
            if (bus.lcd_e) begin
                r_rs_q   <= bus.lcd_rs;
                r_rw_q   <= bus.lcd_rw;
                r_data_q <= bus.lcd_data;
            end

            r_dout_en <= bus.lcd_e & bus.lcd_rw;
            if (bus.lcd_e & bus.lcd_rw)
                r_dout <= bus.lcd_rs ? w_cell : {r_busy, r_ac};
            else
                r_dout <= 8'd0;

            if (r_state != S_IDLE && !w_cnt_done)
                r_cnt <= r_cnt - 32'd1;

            unique case (r_state)
                S_POWERUP: begin
                    if (w_cnt_done) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                S_IDLE: begin
                    if (w_accept) begin
                        r_op_rs    <= r_rs_q;
                        r_op_data  <= r_data_q;
                        r_cmd_stb  <= ~r_rs_q;
                        r_data_stb <= r_rs_q;
                        r_busy     <= 1'b1;
                        r_cnt      <= w_long ? 32'(CLEAR_CYCLES - 1) : 32'(BUSY_CYCLES - 1);
                        r_state    <= S_EXEC;
                    end else if (w_dread) begin
                        r_ac <= f_step(r_ac, r_inc);
                    end
                end

                S_EXEC: begin
                    if (r_op_rs) begin
                        if (!r_cgram) begin
                            if (r_ac < 7'h10)
                                r_line1[{~r_ac[3:0], 3'b000} +: 8] <= r_op_data;
                            else if (r_ac[6:4] == 3'b100)
                                r_line2[{~r_ac[3:0], 3'b000} +: 8] <= r_op_data;
                            r_ac <= f_step(r_ac, r_inc);
                        end
                    end else begin
                        casez (r_op_data)
                            8'b1???????: begin
                                if (w_addr_ok) begin
                                    r_ac    <= r_op_data[6:0];
                                    r_cgram <= 1'b0;
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                            8'b01??????: r_cgram <= 1'b1;
                            8'b001?????: begin
                                r_f8 <= r_op_data[4];
                                r_f2 <= r_op_data[3];
                            end
                            8'b0001????: begin
                                if (!r_op_data[3])
                                    r_ac <= f_step(r_ac, r_op_data[2]);
                            end
                            8'b00001???: begin
                                r_disp   <= r_op_data[2];
                                r_cursor <= r_op_data[1];
                                r_blink  <= r_op_data[0];
                            end
                            8'b000001??: r_inc <= r_op_data[1];
                            8'b0000001?: r_ac  <= 7'd0;
                            8'b00000001: begin
                                r_ac    <= 7'd0;
                                r_inc   <= 1'b1;
                                r_cgram <= 1'b0;
                            end
                            default: ;
                        endcase
                    end

                    if (!r_op_rs && r_op_data == 8'h01) begin
                        r_fill  <= 5'd0;
                        r_state <= S_CLEAR;
                    end else if (w_cnt_done) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_BUSY;
                    end
                end

                // One cell per cycle: fill 0..15 is line 1, 16..31 is line 2.
                S_CLEAR: begin
                    if (r_fill[4])
                        r_line2[{~r_fill[3:0], 3'b000} +: 8] <= c_SPACE;
                    else
                        r_line1[{~r_fill[3:0], 3'b000} +: 8] <= c_SPACE;
                    r_fill <= r_fill + 5'd1;
                    if (r_fill == 5'd31) begin
                        if (w_cnt_done) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end

                S_BUSY: begin
                    if (w_cnt_done) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.lcd_dout    = r_dout;
    assign bus.lcd_dout_en = r_dout_en;
    assign line1           = r_line1;
    assign line2           = r_line2;
    assign addr_counter    = r_ac;
    assign busy            = r_busy;
    assign display_on      = r_disp;
    assign cursor_on       = r_cursor;
    assign blink_on        = r_blink;
    assign inc_mode        = r_inc;
    assign func_8bit       = r_f8;
    assign func_2line      = r_f2;
    assign cmd_strobe      = r_cmd_stb;
    assign data_strobe     = r_data_stb;
    assign protocol_error  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_lcd_responder.sv
//==============================================================================
// Module      : tb_lcd_responder
// Description : Scoreboard bench for lcd_responder with directed bus traffic.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_lcd_responder;

    localparam int c_P = 50;
    localparam int c_B = 20;
    localparam int c_C = 60;
    localparam int c_LIMIT = 5000;

    localparam logic [7:0] c_K_CMD  = 8'd1;
    localparam logic [7:0] c_K_DATA = 8'd2;
    localparam logic [7:0] c_K_ERR  = 8'd3;
    localparam logic [7:0] c_K_READ = 8'd4;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] line1, line2;
    logic [6:0]   addr_counter;
    logic         busy, display_on, cursor_on, blink_on, inc_mode;
    logic         func_8bit, func_2line, cmd_strobe, data_strobe, protocol_error;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [15:0]  exp_q[$];
    logic         prev_en = 1'b0;

    lcd_responder_if bus();

    lcd_responder #(
        .BUSY_CYCLES   (c_B),
        .CLEAR_CYCLES  (c_C),
        .POWERUP_CYCLES(c_P)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .line1         (line1),
        .line2         (line2),
        .addr_counter  (addr_counter),
        .busy          (busy),
        .display_on    (display_on),
        .cursor_on     (cursor_on),
        .blink_on      (blink_on),
        .inc_mode      (inc_mode),
        .func_8bit     (func_8bit),
        .func_2line    (func_2line),
        .cmd_strobe    (cmd_strobe),
        .data_strobe   (data_strobe),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic observe(input logic [15:0] ev);
        logic [15:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got %h expected none", ev);
        end else begin
            e = exp_q.pop_front();
            if (e !== ev) begin
                n_fail++;
                $display("FAIL sb_event: got %h expected %h", ev, e);
            end
        end
    endtask

    // Monitor: every strobe, error pulse and start of a read is one scoreboard event.
    always @(negedge clk) begin
        if (reset) begin
            prev_en = 1'b0;
        end else begin
            if (cmd_strobe)     observe({c_K_CMD, 8'd0});
            if (data_strobe)    observe({c_K_DATA, 8'd0});
            if (protocol_error) observe({c_K_ERR, 8'd0});
            if (bus.lcd_dout_en && !prev_en) observe({c_K_READ, bus.lcd_dout});
            prev_en = bus.lcd_dout_en;
        end
    end

    task automatic bus_op(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_data = d; bus.lcd_e = 1'b1;
        repeat (2) @(negedge clk);
        bus.lcd_e = 1'b0;
        @(negedge clk);
    endtask

    task automatic measure_busy(input string name, input int exp_len);
        int n = 0;
        while (busy === 1'b1 && n < c_LIMIT) begin
            n++;
            @(negedge clk);
        end
        check(name, 128'(n), 128'(exp_len));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < c_LIMIT) begin
            n++;
            @(negedge clk);
        end
        if (n >= c_LIMIT) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: busy still %b after %0d cycles, expected 0", name, busy, n);
        end
    endtask

    task automatic cmd(input logic [7:0] d);
        exp_q.push_back({c_K_CMD, 8'd0});
        bus_op(1'b0, 1'b0, d);
        measure_busy("cmd_busy_len", (d == 8'h01 || d == 8'h02 || d == 8'h03) ? c_C : c_B);
    endtask

    task automatic dat(input logic [7:0] d);
        exp_q.push_back({c_K_DATA, 8'd0});
        bus_op(1'b1, 1'b0, d);
        measure_busy("data_busy_len", c_B);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] blank;
        logic [127:0] hello;
        logic [127:0] digits;
        blank  = {16{8'h20}};
        hello  = {"HELLO", {11{8'h20}}};
        digits = "0123456789ABCDEF";

        bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_e = 1'b0; bus.lcd_data = 8'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_ac", addr_counter, 0);
        check("rst_inc", inc_mode, 1);
        check("rst_f8", func_8bit, 1);
        check("rst_f2", func_2line, 0);
        check("rst_line1", line1, blank);
        check("rst_line2", line2, blank);
        check("rst_disp", {display_on, cursor_on, blink_on}, 0);
        check("rst_dout", {bus.lcd_dout_en, bus.lcd_dout}, 0);
        reset = 1'b0;

        // Write during power-up is refused
        exp_q.push_back({c_K_ERR, 8'd0});
        bus_op(1'b0, 1'b0, 8'h38);
        repeat (3) @(negedge clk);
        check("early_f2", func_2line, 0);
        wait_idle("powerup_idle");

        cmd(8'h38);
        check("func_f2", func_2line, 1);
        check("func_f8", func_8bit, 1);
        cmd(8'h0F);
        check("disp_cb", {display_on, cursor_on, blink_on}, 3'b111);
        cmd(8'h0C);
        check("disp_on", {display_on, cursor_on, blink_on}, 3'b100);
        cmd(8'h01);
        cmd(8'h06);
        cmd(8'h80);
        dat("H"); dat("E"); dat("L"); dat("L"); dat("O");
        check("hello_line1", line1, hello);
        check("hello_line2", line2, blank);
        check("hello_ac", addr_counter, 7'h05);

        // Data read returns the cell and steps AC
        cmd(8'h80);
        exp_q.push_back({c_K_READ, "H"});
        bus_op(1'b1, 1'b1, 8'h00);
        check("read_step_ac", addr_counter, 7'h01);

        cmd(8'hA7);
        check("ac_27", addr_counter, 7'h27);
        dat("A");
        check("wrap_27_40", addr_counter, 7'h40);
        check("hidden_line1", line1, hello);
        check("hidden_line2", line2, blank);
        cmd(8'hC0);
        for (int i = 0; i < 16; i++) dat(digits[127 - 8*i -: 8]);
        check("line2_fill", line2, digits);
        check("line2_ac", addr_counter, 7'h50);

        // Out-of-range DDRAM address
        exp_q.push_back({c_K_CMD, 8'd0});
        exp_q.push_back({c_K_ERR, 8'd0});
        bus_op(1'b0, 1'b0, 8'hA8);
        measure_busy("bad_addr_busy", c_B);
        check("bad_addr_ac", addr_counter, 7'h50);

        cmd(8'h80);
        cmd(8'h10);
        check("wrap_00_67", addr_counter, 7'h67);
        cmd(8'h14);
        check("wrap_67_00", addr_counter, 7'h00);
        cmd(8'h04);
        check("entry_dec", inc_mode, 0);
        cmd(8'hC0);
        dat("Z");
        check("wrap_40_27", addr_counter, 7'h27);
        check("dec_write", line2, {"Z", digits[119:0]});
        cmd(8'h06);

        // Home, then a write while busy is discarded
        exp_q.push_back({c_K_CMD, 8'd0});
        bus_op(1'b0, 1'b0, 8'h02);
        exp_q.push_back({c_K_ERR, 8'd0});
        bus_op(1'b1, 1'b0, "X");
        wait_idle("home_idle");
        check("home_ac", addr_counter, 0);
        check("home_line1", line1, hello);

        // Busy-flag read during clear
        exp_q.push_back({c_K_CMD, 8'd0});
        bus_op(1'b0, 1'b0, 8'h01);
        repeat (5) @(negedge clk);
        exp_q.push_back({c_K_READ, 8'h80});
        @(negedge clk);
        bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b1; bus.lcd_e = 1'b1;
        repeat (2) @(negedge clk);
        check("bf_read", {bus.lcd_dout_en, bus.lcd_dout}, {1'b1, 8'h80});
        bus.lcd_e = 1'b0;
        @(negedge clk);
        wait_idle("clear_idle");
        check("clear_line1", line1, blank);
        check("clear_line2", line2, blank);
        check("clear_ac", addr_counter, 0);

        // Reset in the middle of the clear fill
        cmd(8'h80);
        dat("Q");
        exp_q.push_back({c_K_CMD, 8'd0});
        bus_op(1'b0, 1'b0, 8'h01);
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_line1", line1, blank);
        check("abort_line2", line2, blank);
        check("abort_ac", addr_counter, 0);
        check("abort_flags", {busy, inc_mode, func_8bit, func_2line, display_on, cursor_on, blink_on}, 7'b1110000);
        check("abort_pulses", {cmd_strobe, data_strobe, protocol_error, bus.lcd_dout_en}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        check("sb_drained", 128'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
